// File: rtl/reset_seq_pkg.sv
// reset_sequencer shared types
// FSM state encoding and reset-cause codes
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-assert / sync-deassert chain
// ports: clk, rst_n (async, active low), sync (high once released)
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged, ordered release of domain resets
// ports: clk, reset (async low), soft_req, rst_n_out, ready, reset_cause
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 3,
  parameter int STAGE_GAP   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   ready,
  output logic [1:0]             reset_cause
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  seq_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] idx;
  logic          sync_ok;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .sync  (sync_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ASSERT;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      rst_n_out   <= '0;
      ready       <= 1'b0;
      reset_cause <= CAUSE_EXT;
    end else begin
      unique case (state)
        ASSERT: begin
          if (sync_ok) begin
            if (hold_cnt == HOLD_LAST) begin
              rst_n_out <= NUM_DOMAINS'(1);
              gap_cnt   <= '0;
              idx       <= IW'(1);
              // a single domain finishes on its first release
              if (NUM_DOMAINS == 1) begin
                ready <= 1'b1;
                state <= RUN;
              end else begin
                state <= RELEASE;
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            rst_n_out <= rst_n_out | (NUM_DOMAINS'(1) << idx);
            gap_cnt   <= '0;
            if (idx == IDX_LAST) begin
              ready <= 1'b1;
              state <= RUN;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        RUN: begin
          // synchronizer stays released, so hold restarts next edge
          if (soft_req) begin
            rst_n_out   <= '0;
            ready       <= 1'b0;
            reset_cause <= CAUSE_SOFT;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            idx         <= '0;
            state       <= ASSERT;
          end
        end
        default: begin
          state <= ASSERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: random + directed check vs edge-count model
// drives a default instance and a 1-domain corner instance
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       soft_req = 1'b0;
  logic [2:0] rst_a;
  logic       ready_a;
  logic [1:0] cause_a;
  logic [0:0] rst_b;
  logic       ready_b;
  logic [1:0] cause_b;

  reset_sequencer u_a (
    .clk         (clk),
    .reset       (reset),
    .soft_req    (soft_req),
    .rst_n_out   (rst_a),
    .ready       (ready_a),
    .reset_cause (cause_a)
  );

  reset_sequencer #(
    .SYNC_STAGES (2),
    .HOLD_CYCLES (1),
    .NUM_DOMAINS (1),
    .STAGE_GAP   (8)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .soft_req    (soft_req),
    .rst_n_out   (rst_b),
    .ready       (ready_b),
    .reset_cause (cause_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  // model: domain k is out of reset once the edge count since
  // the sequence origin reaches base + hold + k*gap
  int nd[2]   = '{3, 1};
  int hold[2] = '{16, 1};
  int gap[2]  = '{8, 8};
  int sync[2] = '{2, 2};
  int cnt[2]  = '{0, 0};
  int base[2] = '{2, 2};
  logic [1:0] cause[2] = '{CAUSE_EXT, CAUSE_EXT};

  function automatic logic [7:0] exp_mask(int i);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < nd[i]; k++)
      if (cnt[i] >= base[i] + hold[i] + k * gap[i]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic exp_ready(int i);
    logic [7:0] full;
    full = (8'd1 << nd[i]) - 8'd1;
    return exp_mask(i) == full;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h",
               tag, edge_n, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/a_rst"}, 32'(rst_a), 32'(exp_mask(0)));
    check({tag, "/a_rdy"}, 32'(ready_a), 32'(exp_ready(0)));
    check({tag, "/a_cause"}, 32'(cause_a), 32'(cause[0]));
    check({tag, "/b_rst"}, 32'(rst_b), 32'(exp_mask(1)));
    check({tag, "/b_rdy"}, 32'(ready_b), 32'(exp_ready(1)));
    check({tag, "/b_cause"}, 32'(cause_b), 32'(cause[1]));
  endtask

  task automatic model_ext();
    for (int i = 0; i < 2; i++) begin
      cnt[i]   = 0;
      base[i]  = sync[i];
      cause[i] = CAUSE_EXT;
    end
  endtask

  task automatic step(input bit sreq);
    @(negedge clk);
    soft_req = sreq;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (sreq && exp_ready(i)) begin
          cnt[i]   = 0;
          base[i]  = 0;
          cause[i] = CAUSE_SOFT;
        end else if (cnt[i] < 1000000) begin
          cnt[i]++;
        end
      end
    end
    #1;
    soft_req = 1'b0;
    check_all("cyc");
  endtask

  task automatic reset_long(input int cycles);
    reset = 1'b0;
    model_ext();
    #1;
    check_all("rst_lo");
    repeat (cycles) step(1'b0);
    reset = 1'b1;
    edge_n = 0;
  endtask

  // 3 ns low pulse, entirely between two rising edges
  task automatic glitch();
    reset = 1'b0;
    model_ext();
    #1;
    check_all("glitch");
    #2;
    reset = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #1;
    // power-on
    reset_long(3);
    step(1'b0);
    step(1'b0);
    check("po_b_e2", 32'(ready_b), 32'd0);
    step(1'b0);
    check("po_b_e3", 32'(ready_b), 32'd1);
    check("po_b_rst_e3", 32'(rst_b), 32'd1);
    repeat (14) step(1'b0);
    check("po_e17", 32'(rst_a), 32'd0);
    step(1'b0);
    check("po_e18", 32'(rst_a), 32'd1);
    repeat (7) step(1'b0);
    check("po_e25", 32'(rst_a), 32'd1);
    step(1'b0);
    check("po_e26", 32'(rst_a), 32'd3);
    repeat (7) step(1'b0);
    check("po_e33", 32'(rst_a), 32'd3);
    check("po_rdy_e33", 32'(ready_a), 32'd0);
    step(1'b0);
    check("po_e34", 32'(rst_a), 32'd7);
    check("po_rdy_e34", 32'(ready_a), 32'd1);
    check("po_cause", 32'(cause_a), 32'(CAUSE_EXT));
    repeat (6) step(1'b0);

    // soft reset in RUN
    step(1'b1);
    check("soft_e", 32'(rst_a), 32'd0);
    check("soft_cause", 32'(cause_a), 32'(CAUSE_SOFT));
    repeat (15) step(1'b0);
    check("soft_e15", 32'(rst_a), 32'd0);
    step(1'b0);
    check("soft_e16", 32'(rst_a), 32'd1);
    repeat (24) step(1'b0);

    // request during RELEASE is ignored
    reset_long(3);
    repeat (19) step(1'b0);
    step(1'b1);
    repeat (20) step(1'b0);
    check("ign_e40", 32'(rst_a), 32'd7);
    check("ign_cause", 32'(cause_a), 32'(CAUSE_EXT));

    // abort mid-release between edges 27 and 28
    reset_long(3);
    repeat (27) step(1'b0);
    check("abort_pre", 32'(rst_a), 32'd3);
    glitch();
    check("abort_now", 32'(rst_a), 32'd0);
    repeat (40) step(1'b0);

    // external reset during a soft sequence
    step(1'b1);
    repeat (5) step(1'b0);
    reset_long(4);
    repeat (40) step(1'b0);
    check("rsoft_cause", 32'(cause_a), 32'(CAUSE_EXT));

    // random mix
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 299));
      if (r == 0)
        reset_long(int'($urandom_range(1, 6)));
      else if (r < 3)
        glitch();
      else
        step($urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
